// File: rtl/proc_stream_pkg.sv
// Shared types for the streaming accumulator unit: FSM state codes and ALU opcodes.
package proc_stream_pkg;

    localparam int Q_W = 3;

    typedef enum logic [Q_W-1:0] {
        IDLE = 3'b000,
        EXEC = 3'b001,
        DONE = 3'b010
    } state_e;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_ADD  = 2'b01,
        OP_XOR  = 2'b10,
        OP_SHL  = 2'b11
    } op_e;

endpackage

// File: rtl/sticky_status_reg.sv
// Compresses raw event flags into OR-reduced groups and holds them sticky until cleared.
module sticky_status_reg #(
    parameter int FLAG_W = 16,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [FLAG_W-1:0] flags,
    input  logic              clr,
    output logic [STAT_W-1:0] status
);

    localparam int G = FLAG_W / STAT_W;

    logic [STAT_W-1:0] hit_p0;

    always_comb begin
        hit_p0 = '0;
        for (int i = 0; i < STAT_W; i++) begin
            hit_p0[i] = |flags[i*G +: G];
        end
    end

    // A new hit in the same cycle as a clear survives the clear.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            status <= '0;
        end else begin
            status <= (status & ~{STAT_W{clr}}) | hit_p0;
        end
    end

endmodule

// File: rtl/proc_stream_unit.sv
// Valid/ready operand-in, result-out accumulator unit with a three-state control FSM
// and a sticky compressed status register.
module proc_stream_unit
    import proc_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 16,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] i_data,
    input  logic              data_select,
    input  logic [1:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              carry,
    input  logic [FLAG_W-1:0] status_flags,
    input  logic              status_clr,
    output logic [STAT_W-1:0] status,
    output logic [Q_W-1:0]    Q
);

    localparam int SH_W = $clog2(DATA_W);

    // Result is {carry, value}; only ADD can produce a carry.
    function automatic logic [DATA_W:0] alu(
        input op_e               o,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] r;
        case (o)
            OP_PASS: r = {1'b0, b};
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SHL:  r = {1'b0, a << b[SH_W-1:0]};
            default: r = {1'b0, b};
        endcase
        return r;
    endfunction

    state_e            state_q;
    state_e            state_d;
    logic              accept;
    logic [DATA_W-1:0] operand_p0;
    op_e               op_p0;
    logic [DATA_W:0]   alu_res_p0;
    logic [DATA_W-1:0] acc_p1;
    logic [DATA_W-1:0] data_out_p1;
    logic              carry_p1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Unused encodings fall back to IDLE on the next edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept    = (state_q == IDLE) && in_valid;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Q         = state_q;

    // Stage p0: operand source and opcode captured on accept.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            operand_p0 <= '0;
            op_p0      <= OP_PASS;
        end else if (accept) begin
            operand_p0 <= data_select ? i_data : data_in;
            op_p0      <= op_e'(op);
        end
    end

    assign alu_res_p0 = alu(op_p0, acc_p1, operand_p0);

    // Stage p1: accumulator and result register update only in EXEC, so the
    // result stays frozen through any backpressure in DONE.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc_p1      <= '0;
            data_out_p1 <= '0;
            carry_p1    <= 1'b0;
        end else if (state_q == EXEC) begin
            acc_p1      <= alu_res_p0[DATA_W-1:0];
            data_out_p1 <= alu_res_p0[DATA_W-1:0];
            carry_p1    <= alu_res_p0[DATA_W];
        end
    end

    assign data_out = data_out_p1;
    assign carry    = carry_p1;

    sticky_status_reg #(
        .FLAG_W (FLAG_W),
        .STAT_W (STAT_W)
    ) u_status (
        .clk    (clk),
        .rstN   (rstN),
        .flags  (status_flags),
        .clr    (status_clr),
        .status (status)
    );

endmodule

// File: tb/tb_proc_stream_unit.sv
// Directed bench for proc_stream_unit with a transaction-level result model and status model.
module tb_proc_stream_unit;

    localparam int DATA_W = 32;
    localparam int FLAG_W = 16;
    localparam int STAT_W = 8;
    localparam logic [1:0] PASS = 2'd0, ADD = 2'd1, XOR = 2'd2, SHL = 2'd3;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] i_data = '0;
    logic              data_select = 1'b0;
    logic [1:0]        op = 2'd0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              carry;
    logic [FLAG_W-1:0] status_flags = '0;
    logic              status_clr = 1'b0;
    logic [STAT_W-1:0] status;
    logic [2:0]        Q;

    proc_stream_unit #(.DATA_W(DATA_W), .FLAG_W(FLAG_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .i_data(i_data), .data_select(data_select), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .carry(carry),
        .status_flags(status_flags), .status_clr(status_clr), .status(status), .Q(Q)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result model: accumulator value and carry computed with plain arithmetic.
    logic [DATA_W-1:0] m_acc = '0;
    logic              m_cy = 1'b0;
    logic [DATA_W:0]   exp_q[$];

    task automatic model_exec(input logic [1:0] o, input logic [DATA_W-1:0] v);
        longint unsigned sum;
        case (o)
            PASS: begin m_acc = v; m_cy = 1'b0; end
            ADD: begin
                sum   = {32'h0, m_acc} + {32'h0, v};
                m_acc = 32'(sum % 64'h1_0000_0000);
                m_cy  = (sum >= 64'h1_0000_0000);
            end
            XOR: begin m_acc = m_acc ^ v; m_cy = 1'b0; end
            default: begin m_acc = m_acc << v[4:0]; m_cy = 1'b0; end
        endcase
        exp_q.push_back({m_cy, m_acc});
    endtask

    // Status model: a group bit is set if any of its two flags is set, sticky until cleared.
    logic [STAT_W-1:0] m_stat = '0;
    always @(posedge clk or negedge rstN) begin
        logic [STAT_W-1:0] nxt;
        if (!rstN) begin
            m_stat = '0;
        end else begin
            nxt = status_clr ? '0 : m_stat;
            for (int g = 0; g < STAT_W; g++)
                if (status_flags[2*g] || status_flags[2*g+1]) nxt[g] = 1'b1;
            m_stat = nxt;
        end
    end

    always @(negedge clk) begin
        if (rstN) begin
            chk("status", 64'(status), 64'(m_stat));
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_valid_unrequested: got out_valid 1 expected 0 at %0t", $time);
                end else begin
                    chk("data_out", 64'(data_out), 64'(exp_q[0][DATA_W-1:0]));
                    chk("carry", 64'(carry), 64'(exp_q[0][DATA_W]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic request(input logic sel, input logic [1:0] o,
                           input logic [DATA_W-1:0] din, input logic [DATA_W-1:0] imm);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        data_select = sel; op = o; data_in = din; i_data = imm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_exec(o, sel ? imm : din);
    endtask

    task automatic run_op(input logic sel, input logic [1:0] o,
                          input logic [DATA_W-1:0] din, input logic [DATA_W-1:0] imm,
                          output logic [DATA_W-1:0] res, output logic cy);
        request(sel, o, din, imm);
        chk("q_exec", 64'(Q), 64'd1);
        chk("out_valid_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("out_valid_latency", 64'(out_valid), 64'd1);
        chk("q_done", 64'(Q), 64'd2);
        res = data_out;
        cy  = carry;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("q_idle_after", 64'(Q), 64'd0);
        chk("in_ready_after", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] r;
        logic              c;

        // Reset held while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid; status_flags = ~status_flags; status_clr = ~status_clr;
            op = op + 2'd1; data_in = data_in + 32'h11;
            chk("rst_q", 64'(Q), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_data_out", 64'(data_out), 64'd0);
            chk("rst_status", 64'(status), 64'd0);
            chk("rst_carry", 64'(carry), 64'd0);
        end
        in_valid = 1'b0; status_flags = '0; status_clr = 1'b0; op = PASS;
        @(posedge clk); #1;
        rstN = 1'b1;

        // PASS then ADD from the immediate.
        run_op(1'b0, PASS, 32'h0000_0005, 32'h0, r, c);
        chk("pass5", 64'(r), 64'h5);
        run_op(1'b1, ADD, 32'hDEAD_0000, 32'h3, r, c);
        chk("add3", 64'(r), 64'h8);
        chk("add3_carry", 64'(c), 64'd0);

        // ADD overflow, then XOR clears carry.
        run_op(1'b0, PASS, 32'hFFFF_FFFF, 32'h0, r, c);
        run_op(1'b1, ADD, 32'h0, 32'h2, r, c);
        chk("ovf_sum", 64'(r), 64'h1);
        chk("ovf_carry", 64'(c), 64'd1);
        run_op(1'b0, XOR, 32'h0, 32'h0, r, c);
        chk("xor_carry", 64'(c), 64'd0);

        // Backpressure on a SHL result.
        run_op(1'b0, PASS, 32'h1, 32'h0, r, c);
        request(1'b1, SHL, 32'h0, 32'h4);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", 64'(data_out), 64'h10);
            chk("bp_q", 64'(Q), 64'd2);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            in_valid = (i % 2 == 0);
            data_in = 32'h5555_0000 + 32'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_still_done", 64'(Q), 64'd2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_q", 64'(Q), 64'd0);
        @(posedge clk); #1;
        chk("bp_no_ghost_accept", 64'(Q), 64'd0);

        // Sticky status with clear-versus-set priority.
        status_flags = 16'h0100;
        @(posedge clk); #1;
        status_flags = '0;
        chk("stat_set", 64'(status), 64'h10);
        @(posedge clk); #1;
        chk("stat_sticky", 64'(status), 64'h10);
        status_flags = 16'h0001; status_clr = 1'b1;
        @(posedge clk); #1;
        status_flags = '0; status_clr = 1'b0;
        chk("stat_clr_new_wins", 64'(status), 64'h01);
        status_clr = 1'b1;
        @(posedge clk); #1;
        status_clr = 1'b0;
        chk("stat_cleared", 64'(status), 64'h0);

        // Reset dropped while in DONE aborts the request and zeroes the accumulator.
        request(1'b0, PASS, 32'h0000_ABCD, 32'h0);
        @(posedge clk); #1;
        chk("mid_q_done", 64'(Q), 64'd2);
        rstN = 1'b0;
        #1;
        exp_q.delete();
        m_acc = '0; m_cy = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_q", 64'(Q), 64'd0);
        chk("mid_rst_data", 64'(data_out), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rstN = 1'b1;
        run_op(1'b1, ADD, 32'h0, 32'h7, r, c);
        chk("acc_zeroed", 64'(r), 64'h7);

        // Shift amount uses only the low five operand bits.
        run_op(1'b1, SHL, 32'h0, 32'h0000_0025, r, c);
        chk("shl_mask", 64'(r), 64'hE0);
        run_op(1'b0, XOR, 32'hF0F0_00FF, 32'h0, r, c);
        run_op(1'b0, ADD, 32'h0F0F_FF00, 32'h0, r, c);
        run_op(1'b1, SHL, 32'h0, 32'h1F, r, c);

        repeat (2) @(posedge clk);
        #1;
        chk("results_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
